cpu_clock_gen: RTL and testbench

//  Generates the 6809 E/Q bus clocks from the master clock and stretches each bus cycle per SAM rate bits R[1:0].

---
 rtl/cpu_clock_gen.sv | 84 ++++++++
 tb/tb_cpu_clock_gen.sv | 131 +++++++++++++
 2 files changed

// File: rtl/cpu_clock_gen.sv
// cpu_clock_gen: 6809 E/Q bus clock generator with SAM-rate cycle stretching.
// Optional VIDEO_SLOT_EN macro lets vidReq force a slow cycle at the decision point.
module cpu_clock_gen #(
  parameter int SLOW_DIV = 16,
  parameter int FAST_DIV = 8
) (
  input  logic       clk,
  input  logic       nRST,
  input  logic [1:0] rate,
  input  logic       slowBlock,
  input  logic       vidReq,
  output logic       E,
  output logic       Q,
  output logic       cycleStart,
  output logic       decide,
  output logic       slowCycle
);

  localparam logic [4:0] S_LAST  = 5'(SLOW_DIV - 1);
  localparam logic [4:0] S_Q_ON  = 5'(SLOW_DIV / 4);
  localparam logic [4:0] S_Q_OFF = 5'((3 * SLOW_DIV) / 4);
  localparam logic [4:0] S_E_ON  = 5'(SLOW_DIV / 2);
  localparam logic [4:0] F_LAST  = 5'(FAST_DIV - 1);
  localparam logic [4:0] F_Q_ON  = 5'(FAST_DIV / 4);
  localparam logic [4:0] F_Q_OFF = 5'((3 * FAST_DIV) / 4);
  localparam logic [4:0] F_E_ON  = 5'(FAST_DIV / 2);

  logic [4:0] ph;
  logic [4:0] ph_n;
  logic       running;
  logic       slow_req;
  logic       slow_n;

`ifdef VIDEO_SLOT_EN
  assign slow_req = (rate == 2'b00) | ((rate == 2'b01) & slowBlock) | vidReq;
`else
  logic unused_vid;
  assign unused_vid = vidReq;
  assign slow_req   = (rate == 2'b00) | ((rate == 2'b01) & slowBlock);
`endif

  // Wrap uses the current mode; E/Q are low in phases 0-1 either way.
  always_comb begin
    ph_n   = 5'd0;
    slow_n = slowCycle;
    if (ph != (slowCycle ? S_LAST : F_LAST))
      ph_n = ph + 5'd1;
    if (ph == 5'd1)
      slow_n = slow_req;
  end

  // Outputs are decoded from the phase/mode they will be aligned with.
  always_ff @(posedge clk) begin
    if (!nRST) begin
      ph         <= 5'd0;
      running    <= 1'b0;
      E          <= 1'b0;
      Q          <= 1'b0;
      cycleStart <= 1'b0;
      decide     <= 1'b0;
      slowCycle  <= 1'b1;
    end else if (!running) begin
      running    <= 1'b1;
      ph         <= 5'd0;
      cycleStart <= 1'b1;
      decide     <= 1'b0;
      E          <= 1'b0;
      Q          <= 1'b0;
    end else begin
      ph         <= ph_n;
      slowCycle  <= slow_n;
      cycleStart <= (ph_n == 5'd0);
      decide     <= (ph_n == 5'd1);
      if (slow_n) begin
        Q <= (ph_n >= S_Q_ON) && (ph_n < S_Q_OFF);
        E <= (ph_n >= S_E_ON);
      end else begin
        Q <= (ph_n >= F_Q_ON) && (ph_n < F_Q_OFF);
        E <= (ph_n >= F_E_ON);
      end
    end
  end

endmodule

// File: tb/tb_cpu_clock_gen.sv
// Directed bench for cpu_clock_gen with default SLOW_DIV=16, FAST_DIV=8.
module tb_cpu_clock_gen;

  logic       clk = 1'b0;
  logic       nRST;
  logic [1:0] rate;
  logic       slowBlock;
  logic       vidReq;
  logic       E, Q, cycleStart, decide, slowCycle;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  cpu_clock_gen #(.SLOW_DIV(16), .FAST_DIV(8)) dut (
    .clk       (clk),
    .nRST      (nRST),
    .rate      (rate),
    .slowBlock (slowBlock),
    .vidReq    (vidReq),
    .E         (E),
    .Q         (Q),
    .cycleStart(cycleStart),
    .decide    (decide),
    .slowCycle (slowCycle)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Entered in phase 0; runs one bus cycle of expected length L and returns in phase 0 of the next.
  // Inputs r/sb/vid are presented only during phase 1; other phases carry optional noise.
  task automatic run_cycle(input string name, input int L, input logic [1:0] r, input logic sb,
                           input logic vid, input logic noise, input int mid_at,
                           input logic [1:0] mid_rate, input int abort_at);
    for (int p = 0; p < L; p++) begin
      chk($sformatf("%s cycleStart p%0d", name, p), cycleStart, p == 0);
      chk($sformatf("%s decide p%0d", name, p), decide, p == 1);
      chk($sformatf("%s Q p%0d", name, p), Q, (p >= L / 4) && (p < (3 * L) / 4));
      chk($sformatf("%s E p%0d", name, p), E, p >= L / 2);
      if (p >= 2)
        chk($sformatf("%s slowCycle p%0d", name, p), slowCycle, L == 16);
      if (p == 1) begin
        rate      = r;
        slowBlock = sb;
        vidReq    = vid;
      end else begin
        slowBlock = noise ? (p % 2 == 1) : 1'b0;
        vidReq    = noise ? (p % 2 == 0) : 1'b0;
      end
      if (p == mid_at) rate = mid_rate;
      if (p == abort_at) begin
        nRST = 1'b0;
        tick();
        chk($sformatf("%s abort E", name), E, 1'b0);
        chk($sformatf("%s abort Q", name), Q, 1'b0);
        chk($sformatf("%s abort cycleStart", name), cycleStart, 1'b0);
        chk($sformatf("%s abort slowCycle", name), slowCycle, 1'b1);
        return;
      end
      tick();
    end
  endtask

  initial begin
    nRST      = 1'b0;
    rate      = 2'b00;
    slowBlock = 1'b0;
    vidReq    = 1'b0;

    // Reset held for three edges
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst E", E, 1'b0);
      chk("rst Q", Q, 1'b0);
      chk("rst cycleStart", cycleStart, 1'b0);
      chk("rst decide", decide, 1'b0);
      chk("rst slowCycle", slowCycle, 1'b1);
    end
    nRST = 1'b1;
    tick();
    chk("release cycleStart", cycleStart, 1'b1);
    chk("release slowCycle", slowCycle, 1'b1);

    // Steady slow
    run_cycle("slow0", 16, 2'b00, 1'b0, 1'b0, 1'b0, -1, 2'b00, -1);
    run_cycle("slow1", 16, 2'b00, 1'b0, 1'b0, 1'b0, -1, 2'b00, -1);
    // Steady fast, slowBlock toggling must not matter
    run_cycle("fast0", 8, 2'b10, 1'b1, 1'b0, 1'b1, -1, 2'b00, -1);
    run_cycle("fast1", 8, 2'b11, 1'b1, 1'b0, 1'b1, -1, 2'b00, -1);
    // Address-dependent mode
    run_cycle("adr0", 16, 2'b01, 1'b1, 1'b0, 1'b0, -1, 2'b00, -1);
    run_cycle("adr1", 8, 2'b01, 1'b0, 1'b0, 1'b0, -1, 2'b00, -1);
    run_cycle("adr2", 16, 2'b01, 1'b1, 1'b0, 1'b0, -1, 2'b00, -1);
    run_cycle("adr3", 8, 2'b01, 1'b0, 1'b0, 1'b1, -1, 2'b00, -1);
    // Mid-cycle rate write lands at the next decision point
    run_cycle("midw", 8, 2'b10, 1'b0, 1'b0, 1'b0, 6, 2'b00, -1);
    run_cycle("aftw", 16, 2'b00, 1'b0, 1'b0, 1'b0, -1, 2'b00, -1);
    // Reset mid slow cycle at phase 10
    run_cycle("abrt", 16, 2'b00, 1'b0, 1'b0, 1'b0, -1, 2'b00, 10);
    nRST = 1'b1;
    tick();
    chk("rerelease cycleStart", cycleStart, 1'b1);
    chk("rerelease E", E, 1'b0);
    run_cycle("post", 16, 2'b00, 1'b0, 1'b0, 1'b0, -1, 2'b00, -1);
    // Video slot request on a fast rate
`ifdef VIDEO_SLOT_EN
    run_cycle("vid", 16, 2'b10, 1'b0, 1'b1, 1'b1, -1, 2'b00, -1);
`else
    run_cycle("vid", 8, 2'b10, 1'b0, 1'b1, 1'b1, -1, 2'b00, -1);
`endif
    run_cycle("novid", 8, 2'b10, 1'b0, 1'b0, 1'b1, -1, 2'b00, -1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
